// File: rtl/serdes_lane_reset_seq.sv
// rtl/serdes_lane_reset_seq.sv - per-lane GTY TX/RX reset sequencer; retry/lock-loss stats built only with SERDES_RESET_STATS_EN
module serdes_lane_reset_seq #(
    parameter int LOCK_STABLE   = 1024,
    parameter int TX_SETTLE     = 256,
    parameter int RX_HOLD       = 64,
    parameter int ALIGN_TIMEOUT = 16384
) (
    input  logic       clk_156m25,
    input  logic       rst_n,
    input  logic       qpll_lock,
    input  logic       rx_comma_is_aligned,
    input  logic       force_reset,
    output logic       tx_reset,
    output logic       rx_reset,
    output logic       link_ready,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);
    localparam int MAX_A   = (LOCK_STABLE > TX_SETTLE) ? LOCK_STABLE : TX_SETTLE;
    localparam int MAX_B   = (RX_HOLD > ALIGN_TIMEOUT) ? RX_HOLD : ALIGN_TIMEOUT;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] LD_LOCK  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] LD_TX    = CW'(TX_SETTLE - 1);
    localparam logic [CW-1:0] LD_ALIGN = CW'(ALIGN_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(RX_HOLD - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        TX_SETTLE_ST = 3'd1,
        RX_ALIGN  = 3'd2,
        RX_RETRY  = 3'd3,
        UP        = 3'd4
    } state_t;

    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_m, lock_s, aligned_m, aligned_s;
    logic          busy;

    always_ff @(posedge clk_156m25 or negedge rst_n) begin
        if (!rst_n) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            aligned_m <= 1'b0;
            aligned_s <= 1'b0;
        end else begin
            lock_m    <= qpll_lock;
            lock_s    <= lock_m;
            aligned_m <= rx_comma_is_aligned;
            aligned_s <= aligned_m;
        end
    end

    // Lock loss and force_reset only apply once the lane has left WAIT_LOCK.
    assign busy = (st_q == TX_SETTLE_ST) || (st_q == RX_ALIGN) ||
                  (st_q == RX_RETRY) || (st_q == UP);

    always_comb begin
        st_d  = st_q;
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        if (busy && !lock_s) begin
            st_d = WAIT_LOCK;
        end else if (busy && force_reset) begin
            st_d = WAIT_LOCK;
        end else begin
            case (st_q)
                WAIT_LOCK: begin
                    if (!lock_s || force_reset) cnt_d = LD_LOCK;
                    else if (cnt_q == '0)       st_d  = TX_SETTLE_ST;
                end
                TX_SETTLE_ST: if (cnt_q == '0) st_d = RX_ALIGN;
                RX_ALIGN: begin
                    if (aligned_s)          st_d = UP;
                    else if (cnt_q == '0)   st_d = RX_RETRY;
                end
                RX_RETRY: if (cnt_q == '0) st_d = RX_ALIGN;
                UP:       if (!aligned_s)  st_d = RX_RETRY;
                default:  st_d = WAIT_LOCK;
            endcase
        end
        if (st_d != st_q) begin
            case (st_d)
                WAIT_LOCK:    cnt_d = LD_LOCK;
                TX_SETTLE_ST: cnt_d = LD_TX;
                RX_ALIGN:     cnt_d = LD_ALIGN;
                RX_RETRY:     cnt_d = LD_HOLD;
                default:      cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_156m25 or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= WAIT_LOCK;
            cnt_q <= LD_LOCK;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_156m25 or negedge rst_n) begin
        if (!rst_n) begin
            tx_reset   <= 1'b1;
            rx_reset   <= 1'b1;
            link_ready <= 1'b0;
            state      <= 3'd0;
        end else begin
            tx_reset   <= !busy;
            rx_reset   <= !((st_q == RX_ALIGN) || (st_q == UP));
            link_ready <= (st_q == UP);
            state      <= st_q;
        end
    end

`ifdef SERDES_RESET_STATS_EN
    logic       loss_evt;
    logic [7:0] retry_q, loss_q;

    // Counts are delayed one edge so they move together with the registered state.
    always_ff @(posedge clk_156m25 or negedge rst_n) begin
        if (!rst_n) begin
            loss_evt <= 1'b0;
            retry_q  <= 8'h00;
            loss_q   <= 8'h00;
        end else begin
            loss_evt <= busy && !lock_s;
            if ((st_q == RX_RETRY) && (state != RX_RETRY) && (retry_q != 8'hff))
                retry_q <= retry_q + 8'd1;
            if (loss_evt && (loss_q != 8'hff))
                loss_q <= loss_q + 8'd1;
        end
    end

    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
`else
    assign retry_count     = 8'h00;
    assign lock_loss_count = 8'h00;
`endif
endmodule

// File: tb/tb_serdes_lane_reset_seq.sv
// tb/tb_serdes_lane_reset_seq.sv - self-checking bench for serdes_lane_reset_seq
module tb_serdes_lane_reset_seq;
    localparam int LS = 8, TS = 4, RH = 3, AT = 20;
`ifdef SERDES_RESET_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk_156m25 = 1'b0;
    logic       rst_n, qpll_lock, rx_comma_is_aligned, force_reset;
    logic       tx_reset, rx_reset, link_ready;
    logic [7:0] retry_count, lock_loss_count;
    logic [2:0] state;

    always #5 clk_156m25 = ~clk_156m25;

    serdes_lane_reset_seq #(
        .LOCK_STABLE(LS), .TX_SETTLE(TS), .RX_HOLD(RH), .ALIGN_TIMEOUT(AT)
    ) dut (
        .clk_156m25(clk_156m25),
        .rst_n(rst_n),
        .qpll_lock(qpll_lock),
        .rx_comma_is_aligned(rx_comma_is_aligned),
        .force_reset(force_reset),
        .tx_reset(tx_reset),
        .rx_reset(rx_reset),
        .link_ready(link_ready),
        .retry_count(retry_count),
        .lock_loss_count(lock_loss_count),
        .state(state)
    );

    int total = 0, bad = 0, cyc = 0;

    // Reference model: phase plus time-in-phase / lock run length.
    int         m_ph, m_age, m_run, m_ret, m_loss;
    logic       sh_lock0, sh_lock1, sh_al0, sh_al1;
    logic       e_tx, e_rx, e_link;
    logic [2:0] e_state;
    logic [7:0] e_ret, e_loss;

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_run = 0; m_ret = 0; m_loss = 0;
        sh_lock0 = 0; sh_lock1 = 0; sh_al0 = 0; sh_al1 = 0;
        e_tx = 1; e_rx = 1; e_link = 0; e_state = 0; e_ret = 0; e_loss = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  lost, ls, as;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = sh_lock1;
        as = sh_al1;
        e_state = 3'(m_ph);
        e_tx    = (m_ph == 0);
        e_rx    = !(m_ph == 2 || m_ph == 4);
        e_link  = (m_ph == 4);
        e_ret   = STATS ? 8'(m_ret) : 8'd0;
        e_loss  = STATS ? 8'(m_loss) : 8'd0;
        nxt = m_ph;
        lost = 0;
        if (m_ph != 0 && !ls) begin
            nxt = 0; lost = 1;
        end else if (m_ph != 0 && force_reset) begin
            nxt = 0;
        end else begin
            case (m_ph)
                0: begin
                    if (!ls || force_reset) m_run = 0; else m_run++;
                    if (m_run == LS) nxt = 1;
                end
                1: begin m_age++; if (m_age == TS) nxt = 2; end
                2: begin
                    m_age++;
                    if (as) nxt = 4; else if (m_age == AT) nxt = 3;
                end
                3: begin m_age++; if (m_age == RH) nxt = 2; end
                default: if (!as) nxt = 3;
            endcase
        end
        if (lost && m_loss < 255) m_loss++;
        if (nxt != m_ph) begin
            if (nxt == 3 && m_ret < 255) m_ret++;
            m_age = 0;
            m_run = 0;
        end
        m_ph = nxt;
        sh_lock1 = sh_lock0; sh_lock0 = qpll_lock;
        sh_al1 = sh_al0;     sh_al0 = rx_comma_is_aligned;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        total++;
        if ({tx_reset, rx_reset, link_ready, state, retry_count, lock_loss_count} !==
            {e_tx, e_rx, e_link, e_state, e_ret, e_loss}) begin
            bad++;
            $display("FAIL model at cycle %0d: got tx=%0b rx=%0b link=%0b state=%0d retry=%0d loss=%0d expected tx=%0b rx=%0b link=%0b state=%0d retry=%0d loss=%0d",
                     cyc, tx_reset, rx_reset, link_ready, state, retry_count, lock_loss_count,
                     e_tx, e_rx, e_link, e_state, e_ret, e_loss);
        end
    endtask

    task automatic tick();
        @(posedge clk_156m25);
        model_step();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        qpll_lock = 0; rx_comma_is_aligned = 0; force_reset = 0;
        rst_n = 0;
        model_reset();
        repeat (3) tick();
        rst_n = 1;
        cyc = 0;
    endtask

    typedef struct {
        int         cyc;
        logic       lock;
        logic       al;
        logic       tx;
        logic       rx;
        logic       link;
        logic [2:0] st;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int  last_rise, rise_n, tx_hi;
        logic prev_rx;
        // {check cycle, lock/aligned driven after the check, expected tx/rx/link/state}
        tbl[0] = '{0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[2] = '{20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[3] = '{21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[4] = '{24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[5] = '{25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[6] = '{29, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[7] = '{33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};

        do_reset();
        chk("reset_tx", tx_reset, 1);
        chk("reset_rx", rx_reset, 1);
        chk("reset_link", link_ready, 0);
        chk("reset_state", state, 0);
        chk("reset_retry", retry_count, 0);
        chk("reset_loss", lock_loss_count, 0);

        for (int i = 0; i < 8; i++) begin
            run_to(tbl[i].cyc);
            chk("bringup_tx", tx_reset, tbl[i].tx);
            chk("bringup_rx", rx_reset, tbl[i].rx);
            chk("bringup_link", link_ready, tbl[i].link);
            chk("bringup_state", state, tbl[i].st);
            qpll_lock = tbl[i].lock;
            rx_comma_is_aligned = tbl[i].al;
        end

        // One-cycle alignment drop while UP.
        run_to(35);
        rx_comma_is_aligned = 0;
        run_to(36);
        rx_comma_is_aligned = 1;
        run_to(38); chk("aloss_link_hold", link_ready, 1);
        run_to(39); chk("aloss_link_drop", link_ready, 0);
        chk("aloss_rx", rx_reset, 1);
        chk("aloss_retry", retry_count, STATS ? 1 : 0);
        run_to(41); chk("aloss_rx_hold", rx_reset, 1);
        run_to(42); chk("aloss_rx_rel", rx_reset, 0);
        run_to(43); chk("aloss_link_back", link_ready, 1);
        chk("aloss_tx", tx_reset, 0);

        // Lock loss and force_reset hit the FSM on the same edge.
        run_to(45); qpll_lock = 0;
        run_to(47); force_reset = 1;
        run_to(48); force_reset = 0;
        chk("both_state_pre", state, 4);
        run_to(49);
        chk("both_state", state, 0);
        chk("both_tx", tx_reset, 1);
        chk("both_rx", rx_reset, 1);
        chk("both_loss", lock_loss_count, STATS ? 1 : 0);
        qpll_lock = 1;
        rx_comma_is_aligned = 0;
        run_to(60); chk("relock_tx", tx_reset, 0);
        run_to(70); chk("pre_async_state", state, 2);

        // Async reset between edges while in RX_ALIGN.
        #2;
        rst_n = 0;
        #1;
        chk("async_tx", tx_reset, 1);
        chk("async_rx", rx_reset, 1);
        chk("async_link", link_ready, 0);
        chk("async_state", state, 0);
        chk("async_retry", retry_count, 0);
        chk("async_loss", lock_loss_count, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1;
        cyc = 0;
        run_to(1);  chk("restart_state", state, 0);
        run_to(11); chk("restart_tx", tx_reset, 0);
        run_to(15); chk("restart_rx", rx_reset, 0);

        // Alignment never arrives: periodic RX retries until the count saturates.
        prev_rx = rx_reset;
        last_rise = -1;
        rise_n = 0;
        tx_hi = 0;
        for (int n = 0; n < 260 * 23; n++) begin
            tick();
            if (tx_reset) tx_hi++;
            if (rx_reset && !prev_rx) begin
                if (last_rise >= 0) chk("retry_period", cyc - last_rise, 23);
                last_rise = cyc;
                rise_n++;
            end
            if (!rx_reset && prev_rx) chk("retry_width", cyc - last_rise, 3);
            prev_rx = rx_reset;
        end
        chk("retry_tx_low", tx_hi, 0);
        chk("retry_pulses", rise_n, 260);
        chk("retry_sat", retry_count, STATS ? 255 : 0);

        // Lock glitch while waiting for lock.
        do_reset();
        run_to(5);  qpll_lock = 1;
        run_to(10); qpll_lock = 0;
        run_to(11); qpll_lock = 1;
        run_to(16); chk("glitch_tx_early", tx_reset, 1);
        run_to(21); chk("glitch_tx_hold", tx_reset, 1);
        run_to(22); chk("glitch_tx_rel", tx_reset, 0);

        // Random stimulus against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (qpll_lock) begin
                if ($urandom_range(0, 149) == 0) qpll_lock = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                qpll_lock = 1;
            end
            if (rx_comma_is_aligned) begin
                if ($urandom_range(0, 39) == 0) rx_comma_is_aligned = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                rx_comma_is_aligned = 1;
            end
            force_reset = ($urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
